ccx_ic_router_np: RTL

- Parametrised N-target core complex interconnect router. Sits between one CPU memory port and NP target memory ports (ROM, RAM, EXT, MMIO, ...).
- Decodes each request against per-target base/size windows and forwards it to the matching target.
- Tracks up to MAX_OUT outstanding transactions with variable-latency, in-order responses.
- Synthesises error responses for unmapped addresses.

---
 rtl/ccx_ic_router_np.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ccx_ic_router_np.sv
// Core complex interconnect router: decodes one CPU port onto NP target windows,
// keeps responses in order by only issuing to a new target once all prior ones drained.
module ccx_ic_router_np #(
    parameter int unsigned      AW       = 39,
    parameter int unsigned      DW       = 64,
    parameter int unsigned      TW       = 2,
    parameter int unsigned      NP       = 4,
    parameter int unsigned      MAX_OUT  = 4,
    parameter logic [NP*AW-1:0] MAP_BASE = {39'h0000020000, 39'h7F10000000,
                                            39'h0000010000, 39'h0000000000},
    parameter logic [NP*AW-1:0] MAP_SIZE = {39'h00000000FF, 39'h000FFFFFFF,
                                            39'h000000FFFF, 39'h00000003FF}
) (
    input  logic               g_clk,
    input  logic               g_resetn,
    input  logic               s_req,
    output logic               s_gnt,
    input  logic               s_wen,
    input  logic [DW/8-1:0]    s_strb,
    input  logic [AW-1:0]      s_addr,
    input  logic [DW-1:0]      s_wdata,
    input  logic               s_prv,
    input  logic [TW-1:0]      s_rtype,
    output logic               s_rvalid,
    output logic               s_err,
    output logic [DW-1:0]      s_rdata,
    output logic [NP-1:0]      m_req,
    input  logic [NP-1:0]      m_gnt,
    output logic               m_wen,
    output logic [DW/8-1:0]    m_strb,
    output logic [AW-1:0]      m_addr,
    output logic [DW-1:0]      m_wdata,
    output logic               m_prv,
    output logic [TW-1:0]      m_rtype,
    input  logic [NP-1:0]      m_rvalid,
    input  logic [NP-1:0]      m_err,
    input  logic [NP*DW-1:0]   m_rdata,
    output logic               map_conflict,
    output logic               rsp_unexpected
);

    localparam int unsigned    RW       = $clog2(NP + 1);
    localparam int unsigned    CW       = $clog2(MAX_OUT + 1);
    localparam logic [RW-1:0]  UNMAPPED = RW'(NP);

    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [RW-1:0] cur_route_q, cur_route_d;
    logic          unm_pend_q, unm_pend_d;
    logic          map_conflict_q, map_conflict_d;
    logic          rsp_unexpected_q, rsp_unexpected_d;

    logic [NP-1:0] hit;
    logic [RW-1:0] sel;
    logic          mapped;
    logic          multi_hit;
    logic          rt_valid;
    logic [NP-1:0] exp_mask;
    logic          gnt_sel;
    logic          permit;
    logic          accept;

    assign m_wen   = s_wen;
    assign m_strb  = s_strb;
    assign m_addr  = s_addr;
    assign m_wdata = s_wdata;
    assign m_prv   = s_prv;
    assign m_rtype = s_rtype;

    // Scanning downward leaves the lowest-index hit as the selected route.
    always_comb begin
        hit = '0;
        sel = UNMAPPED;
        for (int unsigned i = 0; i < NP; i++) begin
            hit[i] = ((s_addr & ~MAP_SIZE[i*AW +: AW]) == MAP_BASE[i*AW +: AW]);
        end
        for (int unsigned i = NP; i > 0; i--) begin
            if (hit[i-1]) sel = RW'(i - 1);
        end
    end

    assign mapped    = (sel != UNMAPPED);
    assign multi_hit = |(hit & (hit - NP'(1)));
    assign rt_valid  = (out_cnt_q != '0) && (cur_route_q < UNMAPPED);

    always_comb begin
        exp_mask = '0;
        gnt_sel  = 1'b0;
        s_rvalid = 1'b0;
        s_err    = 1'b0;
        s_rdata  = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            exp_mask[i] = rt_valid && (cur_route_q == RW'(i));
            if (exp_mask[i]) begin
                s_rvalid = m_rvalid[i];
                s_err    = m_err[i];
                s_rdata  = m_rdata[i*DW +: DW];
            end
            if (sel == RW'(i)) gnt_sel = m_gnt[i];
        end
        if (unm_pend_q) begin
            s_rvalid = 1'b1;
            s_err    = 1'b1;
            s_rdata  = '0;
        end
    end

    // A response retiring this cycle frees a slot, so a full queue may still
    // accept; a route change only waits for the registered count to reach 0.
    // Reset is folded in so no request leaks out while it is held.
    assign permit = g_resetn
                 && ((out_cnt_q < CW'(MAX_OUT)) || s_rvalid)
                 && ((out_cnt_q == '0) || (sel == cur_route_q));

    always_comb begin
        m_req = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            if (permit && (sel == RW'(i))) m_req[i] = s_req;
        end
    end

    assign s_gnt  = permit && (mapped ? gnt_sel : s_req);
    assign accept = s_req && s_gnt;

    always_comb begin
        cur_route_d      = accept ? sel : cur_route_q;
        out_cnt_d        = out_cnt_q + CW'(accept) - CW'(s_rvalid);
        unm_pend_d       = accept && !mapped;
        map_conflict_d   = map_conflict_q || (s_req && multi_hit);
        rsp_unexpected_d = rsp_unexpected_q || (|(m_rvalid & ~exp_mask));
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            out_cnt_q        <= '0;
            cur_route_q      <= '0;
            unm_pend_q       <= 1'b0;
            map_conflict_q   <= 1'b0;
            rsp_unexpected_q <= 1'b0;
        end else begin
            out_cnt_q        <= out_cnt_d;
            cur_route_q      <= cur_route_d;
            unm_pend_q       <= unm_pend_d;
            map_conflict_q   <= map_conflict_d;
            rsp_unexpected_q <= rsp_unexpected_d;
        end
    end

    assign map_conflict   = map_conflict_q;
    assign rsp_unexpected = rsp_unexpected_q;

endmodule
